systolic_feed_scheduler: RTL and testbench
==========================================

// Module: systolic_feed_scheduler
// PURPOSE
//  Sequences the per-row input FIFOs that feed the systolic array: issues diagonally skewed
//  read strobes (row r starts r cycles after row 0), then waits out array drain and pulses done.
//  Stalls the whole wavefront if any FIFO due for a read this cycle is empty, so skew stays aligned.
// PARAMETERS
//  ROWS         4   number of row FIFOs / array rows (>=1)
//  LEN_WIDTH    8   width of length input (words per row)
//  DRAIN_CYCLES 8   cycles waited after last read before done (>=1)
//  TIMEOUT      16  consecutive stall cycles before abort (used only with SCHED_TIMEOUT_EN)
// PORTS
//  clk         in   1          clock, rising edge
//  reset       in   1          asynchronous, active-high reset
//  start       in   1          start request, sampled in IDLE only
//  length      in   LEN_WIDTH  words per row; latched on accepted start
//  fifo_empty  in   ROWS       per-row FIFO empty flags
//  fifo_read   out  ROWS       per-row FIFO read strobes
//  stall       out  1          wavefront stalled this cycle
//  busy        out  1          state != IDLE
//  done        out  1          one-cycle completion pulse
//  error       out  1          timeout abort flag (sticky until next accepted start)
// BEHAVIOUR
//  - Reset (async): state=IDLE, all counters 0, fifo_read=0, stall=0, busy=0, done=0, error=0.
//  - States: IDLE -> STREAM -> DRAIN -> DONE -> IDLE.
//  - IDLE: start=1 at edge k -> len latched, cnt=0, error cleared; STREAM from cycle k+1.
//    length==0 -> skip STREAM/DRAIN, DONE at k+1 (no reads).
//  - STREAM: active[r] = (cnt >= r) && (cnt < r+len); stall = |(active & fifo_empty);
//    fifo_read = active & ~{ROWS{stall}} (combinational from registered state + fifo_empty).
//    Empty flags of inactive rows ignored. cnt += 1 when !stall; holds when stall.
//    cnt == len+ROWS-2 && !stall -> DRAIN, dcnt=0. Internal cnt wide enough for len+ROWS-2
//    (LEN_WIDTH+$clog2(ROWS)+1 bits); no wrap possible.
//  - DRAIN: fifo_read=0, stall=0; dcnt counts DRAIN_CYCLES cycles, then DONE.
//  - DONE: done=1 for exactly one cycle, -> IDLE.
//  - start while busy ignored (no queuing); length changes while busy ignored.
//  - busy = (state != IDLE), registered-state decode; asserted in DONE cycle.
//  - Reset mid-operation: fifo_read drops immediately, no done pulse.
// CONFIGURATION
//  SCHED_TIMEOUT_EN defined: stall_cnt counts consecutive STREAM stall cycles (cleared on any
//   non-stall cycle); at TIMEOUT -> IDLE next edge, error=1, no done pulse, fifo_read=0.
//  SCHED_TIMEOUT_EN undefined: no stall counter; STREAM waits indefinitely; error tied 0.
// TESTING (ROWS=4, DRAIN_CYCLES=8, TIMEOUT=16; start pulsed in cycle 0)
//  1 length=3, fifo_empty=0 -> fifo_read[0] cyc1-3, [1] 2-4, [2] 3-5, [3] 4-6;
//    busy 1-15; done only cyc15; busy=0 cyc16.
//  2 As 1, fifo_empty[2]=1 in cyc4 only -> cyc4 fifo_read=0000, stall=1;
//    remaining reads shifted +1; done cyc16.
//  3 As 1, fifo_empty[3]=1 cyc1-3 (row3 inactive) -> no stall, timing identical to 1;
//    start re-pulsed cyc5 -> ignored.
//  4 length=0 -> done cyc1, fifo_read never asserted, busy only cyc1.
//  5 length=3, reset asserted mid-cyc3 -> fifo_read=0, busy=0 immediately;
//    after release, new start length=2 runs normally.
//  6 length=3, fifo_empty[0]=1 throughout -> with SCHED_TIMEOUT_EN: IDLE after 16 stall
//    cycles, error=1, no done; without: stall=1 indefinitely, busy=1, error=0.

Source files
------------

// File: rtl/systolic_feed_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : systolic_feed_scheduler
// Description : Issues diagonally skewed read strobes to the per-row input
//               FIFOs of a systolic array (row r starts r cycles after row 0),
//               stalls the whole wavefront when any due FIFO is empty, waits
//               out the array drain and pulses done.
//               Optional macro SCHED_TIMEOUT_EN adds a consecutive-stall
//               timeout that aborts the run and raises a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_feed_scheduler #(
  parameter int ROWS         = 4,
  parameter int LEN_WIDTH    = 8,
  parameter int DRAIN_CYCLES = 8,
  parameter int TIMEOUT      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] length,
  input  logic [ROWS-1:0]      fifo_empty,
  output logic [ROWS-1:0]      fifo_read,
  output logic                 stall,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  // Wavefront counter must hold len+ROWS-2 without wrapping.
  localparam int CW = LEN_WIDTH + $clog2(ROWS) + 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [LEN_WIDTH-1:0] r_len;
  logic [CW-1:0]        r_cnt;
  logic [DW-1:0]        r_dcnt;

  logic [CW-1:0]        w_len_ext;
  logic [ROWS-1:0]      w_active;
  logic                 w_stall;
  logic                 w_stream_end;
  logic                 w_drain_end;
  logic                 w_timeout;

  assign w_len_ext = CW'(r_len);

  // Which rows are inside their skewed read window, and whether any of them is starved.
  always_comb begin
    w_active = '0;
    for (int r = 0; r < ROWS; r++) begin
      w_active[r] = (r_cnt >= CW'(r)) && (r_cnt < (CW'(r) + w_len_ext));
    end
    w_stall      = (r_state == S_STREAM) && (|(w_active & fifo_empty));
    w_stream_end = (r_cnt == (w_len_ext + CW'(ROWS) - CW'(2))) && !w_stall;
    w_drain_end  = (r_dcnt == DW'(DRAIN_CYCLES - 1));
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_stall_cnt;
  logic          r_error;

  assign w_timeout = w_stall && (r_stall_cnt == TW'(TIMEOUT - 1));
  assign error     = r_error;

  // Count consecutive stalled stream cycles; latch a sticky error on abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_error     <= 1'b0;
    end else begin
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + TW'(1);
      end else begin
        r_stall_cnt <= '0;
      end
      if ((r_state == S_IDLE) && start) begin
        r_error <= 1'b0;
      end else if (w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = (length == '0) ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_timeout) begin
          w_next_state = S_IDLE;
        end else if (w_stream_end) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drain_end) begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Length latch, wavefront counter and drain counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len  <= '0;
      r_cnt  <= '0;
      r_dcnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len  <= length;
            r_cnt  <= '0;
            r_dcnt <= '0;
          end
        end
        S_STREAM: begin
          if (!w_stall) begin
            r_cnt <= r_cnt + CW'(1);
          end
          r_dcnt <= '0;
        end
        S_DRAIN: begin
          r_dcnt <= r_dcnt + DW'(1);
        end
        default: begin
          r_dcnt <= '0;
        end
      endcase
    end
  end

  // Outputs decoded from registered state; read strobes also gated by the stall.
  always_comb begin
    fifo_read = '0;
    stall     = 1'b0;
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    if (r_state == S_STREAM) begin
      stall     = w_stall;
      fifo_read = w_active & ~{ROWS{w_stall}};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_feed_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_feed_scheduler
// Description : Directed self-checking bench for systolic_feed_scheduler
//               (ROWS=4, DRAIN_CYCLES=8, TIMEOUT=16). Expected output vectors
//               are queued as each cycle is driven and checked at the negedge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_feed_scheduler;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] length;
  logic [3:0] fifo_empty;
  logic [3:0] fifo_read;
  logic       stall;
  logic       busy;
  logic       done;
  logic       error;

  int n_assert;
  int n_fail;
  logic [7:0] exp_q[$];

  systolic_feed_scheduler #(
    .ROWS(4), .LEN_WIDTH(8), .DRAIN_CYCLES(8), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .fifo_empty(fifo_empty), .fifo_read(fifo_read), .stall(stall),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: {fifo_read[3:0], stall, busy, done, error}
  function automatic logic [7:0] obs_vec();
    return {fifo_read, stall, busy, done, error};
  endfunction

  // Timeline model of one run started in cycle 0 with length L; s>0 marks a
  // single wavefront stall cycle at cycle s.
  function automatic logic [7:0] model(int c, int L, int s);
    logic [3:0] rd;
    int t;
    rd = '0;
    if (c < 1) return 8'h00;
    if (L == 0) return (c == 1) ? 8'h06 : 8'h00;
    if (s > 0 && c == s) return 8'h0C;
    t = (s > 0 && c > s) ? c - 2 : c - 1;
    if (t <= L + 2) begin
      for (int r = 0; r < 4; r++) rd[r] = (t >= r) && (t < r + L);
      return {rd, 4'b0100};
    end
    if (t <= L + 10) return 8'h04;
    if (t == L + 11) return 8'h06;
    return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue expectation, check at negedge.
  task automatic cyc(input string tag, input logic st, input logic [7:0] len,
                     input logic [3:0] emp, input logic [7:0] exp);
    logic [7:0] e;
    start      = st;
    length     = len;
    fifo_empty = emp;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, obs_vec(), e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input int L, input int s, input int ncyc,
                     input int start2, input logic [3:0] mask, input int ef, input int et);
    for (int c = 0; c < ncyc; c++) begin
      cyc($sformatf("%s_c%0d", tag, c), (c == 0) || (c == start2),
          (c == 0) ? L[7:0] : 8'hFF,
          (c >= ef && c <= et) ? mask : 4'b0000, model(c, L, s));
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    start      = 1'b0;
    length     = 8'd0;
    fifo_empty = 4'b0000;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_state", obs_vec(), 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("post_reset_idle", 1'b0, 8'd3, 4'b0000, 8'h00);

    // 1: nominal length 3
    run("t1", 3, 0, 18, -1, 4'b0000, -1, -1);
    // 2: row 2 empty in cycle 4 stalls the wavefront one cycle
    run("t2", 3, 4, 18, -1, 4'b0100, 4, 4);
    // 3: inactive row 3 empty early, re-start while busy ignored
    run("t3", 3, 0, 18, 5, 4'b1000, 1, 3);
    // 4: zero length
    run("t4", 0, 0, 4, -1, 4'b0000, -1, -1);

    // 5: reset in the middle of cycle 3
    for (int c = 0; c < 3; c++) begin
      cyc($sformatf("t5_c%0d", c), c == 0, 8'd3, 4'b0000, model(c, 3, 0));
    end
    start = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_reset", obs_vec(), 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("t5_idle", 1'b0, 8'd2, 4'b0000, 8'h00);
    run("t5b", 2, 0, 16, -1, 4'b0000, -1, -1);

    // 6: row 0 permanently empty
`ifdef SCHED_TIMEOUT_EN
    for (int c = 0; c < 21; c++) begin
      cyc($sformatf("t6_c%0d", c), c == 0, 8'd3, 4'b0001,
          (c == 0) ? 8'h00 : (c <= 16) ? 8'h0C : 8'h01);
    end
    cyc("t6_err_clr_c0", 1'b1, 8'd0, 4'b0001, 8'h01);
    cyc("t6_err_clr_c1", 1'b0, 8'd0, 4'b0001, 8'h06);
    cyc("t6_err_clr_c2", 1'b0, 8'd0, 4'b0001, 8'h00);
`else
    for (int c = 0; c < 30; c++) begin
      cyc($sformatf("t6_c%0d", c), c == 0, 8'd3, 4'b0001,
          (c == 0) ? 8'h00 : 8'h0C);
    end
    pulse_reset();
    cyc("t6_after_reset", 1'b0, 8'd0, 4'b0000, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
